lsu_mem_master: RTL and testbench

- Load/store unit that drives the external data memory port from the core side. It is the initiator of the mem_req/ready protocol that the external memory answers.
- Accepts one load or store from the core pipeline at a time. Generates byte enables and lane-replicated write data, issues a one-cycle memory request, and waits for ready.
- Returns sign- or zero-extended load data and stalls the core until the access completes.

---
 rtl/lsu_mem_master.sv | 181 ++++++++++++++++++
 tb/tb_lsu_mem_master.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_master.sv
// Load/store unit master for the external data memory port.
// One access at a time: IDLE latches the request, REQ pulses mem_req_o, RESP waits for
// mem_ready_i, DONE releases the core stall for one cycle.
// Optional build macro: LSU_MISALIGN_EN traps misaligned H/W accesses without touching memory.
module lsu_mem_master #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              core_req_i,
  input  logic              core_we_i,
  input  logic [2:0]        core_size_i,
  input  logic [ADDR_W-1:0] core_addr_i,
  input  logic [31:0]       core_wd_i,
  output logic [31:0]       core_rd_o,
  output logic              core_stall_o,
  output logic              core_misalign_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_be_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wd_o,
  input  logic [31:0]       mem_rd_i,
  input  logic              mem_ready_i
);

  typedef enum logic [1:0] {StIdle, StReq, StResp, StDone} state_t;

  state_t            r_state;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [3:0]        r_mem_be;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wd;
  logic [2:0]        r_size;
  logic [31:0]       r_core_rd;

  logic [3:0]        w_be;
  logic [31:0]       w_wd;
  logic [31:0]       w_rd_byte_shift;
  logic [31:0]       w_rd_half_shift;
  logic [31:0]       w_rd_ext;
  logic              w_stall;

`ifdef LSU_MISALIGN_EN
  logic r_misalign;
  logic w_misalign;

  // Halfword needs an even address, word needs a 4-byte aligned address.
  always_comb begin
    w_misalign = 1'b0;
    unique case (core_size_i[1:0])
      2'b00:   w_misalign = 1'b0;
      2'b01:   w_misalign = core_addr_i[0];
      default: w_misalign = (core_addr_i[1:0] != 2'b00);
    endcase
  end

  assign core_misalign_o = r_misalign;
`else
  assign core_misalign_o = 1'b0;
`endif

  // Byte enables and lane-replicated store data from the incoming core request.
  // size[1:0] alone picks the width; undefined codes 011/110/111 fall to word.
  always_comb begin
    w_be = 4'hF;
    w_wd = core_wd_i;
    unique case (core_size_i[1:0])
      2'b00: begin
        w_be = 4'b0001 << core_addr_i[1:0];
        w_wd = {4{core_wd_i[7:0]}};
      end
      2'b01: begin
        w_be = 4'b0011 << {core_addr_i[1], 1'b0};
        w_wd = {2{core_wd_i[15:0]}};
      end
      default: begin
        w_be = 4'hF;
        w_wd = core_wd_i;
      end
    endcase
  end

  // Align the addressed lane of the read word to bit 0 and extend per latched size.
  always_comb begin
    w_rd_byte_shift = mem_rd_i >> {r_mem_addr[1:0], 3'b000};
    w_rd_half_shift = mem_rd_i >> {r_mem_addr[1], 4'b0000};
    w_rd_ext        = mem_rd_i;
    unique case (r_size[1:0])
      2'b00:   w_rd_ext = {{24{~r_size[2] & w_rd_byte_shift[7]}}, w_rd_byte_shift[7:0]};
      2'b01:   w_rd_ext = {{16{~r_size[2] & w_rd_half_shift[15]}}, w_rd_half_shift[15:0]};
      default: w_rd_ext = mem_rd_i;
    endcase
  end

  // Core stall: follows the request in IDLE so the core freezes in the same cycle.
  always_comb begin
    w_stall = 1'b0;
    unique case (r_state)
      StIdle:  w_stall = core_req_i;
      StReq:   w_stall = 1'b1;
      StResp:  w_stall = 1'b1;
      StDone:  w_stall = 1'b0;
      default: w_stall = 1'b0;
    endcase
    if (rst_i) begin
      w_stall = 1'b0;
    end
  end

  // Access FSM with registered memory-side outputs and load result.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= StIdle;
      r_mem_req  <= 1'b0;
      r_mem_we   <= 1'b0;
      r_mem_be   <= 4'h0;
      r_mem_addr <= '0;
      r_mem_wd   <= 32'h0;
      r_size     <= 3'b000;
      r_core_rd  <= 32'h0;
`ifdef LSU_MISALIGN_EN
      r_misalign <= 1'b0;
`endif
    end else begin
      r_mem_req  <= 1'b0;
`ifdef LSU_MISALIGN_EN
      r_misalign <= 1'b0;
`endif
      unique case (r_state)
        StIdle: begin
          if (core_req_i) begin
`ifdef LSU_MISALIGN_EN
            if (w_misalign) begin
              r_misalign <= 1'b1;
              r_state    <= StDone;
            end else begin
`endif
              r_mem_req  <= 1'b1;
              r_mem_we   <= core_we_i;
              r_mem_be   <= w_be;
              r_mem_addr <= core_addr_i;
              r_mem_wd   <= w_wd;
              r_size     <= core_size_i;
              r_state    <= StReq;
`ifdef LSU_MISALIGN_EN
            end
`endif
          end
        end
        StReq: begin
          r_state <= StResp;
        end
        StResp: begin
          if (mem_ready_i) begin
            if (!r_mem_we) begin
              r_core_rd <= w_rd_ext;
            end
            r_state <= StDone;
          end
        end
        StDone: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign core_rd_o    = r_core_rd;
  assign core_stall_o = w_stall;
  assign mem_req_o    = r_mem_req;
  assign mem_we_o     = r_mem_we;
  assign mem_be_o     = r_mem_be;
  assign mem_addr_o   = r_mem_addr;
  assign mem_wd_o     = r_mem_wd;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Self-checking bench for lsu_mem_master: expected transactions are queued at drive time and
// popped when the access completes (stall release).
module tb_lsu_mem_master;

  localparam logic [31:0] Garbage = 32'h5A5A_A5A5;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        core_req_i;
  logic        core_we_i;
  logic [2:0]  core_size_i;
  logic [31:0] core_addr_i;
  logic [31:0] core_wd_i;
  logic [31:0] core_rd_o;
  logic        core_stall_o;
  logic        core_misalign_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wd_o;
  logic [31:0] mem_rd_i;
  logic        mem_ready_i;

  lsu_mem_master #(.ADDR_W(32)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .core_req_i      (core_req_i),
    .core_we_i       (core_we_i),
    .core_size_i     (core_size_i),
    .core_addr_i     (core_addr_i),
    .core_wd_i       (core_wd_i),
    .core_rd_o       (core_rd_o),
    .core_stall_o    (core_stall_o),
    .core_misalign_o (core_misalign_o),
    .mem_req_o       (mem_req_o),
    .mem_we_o        (mem_we_o),
    .mem_be_o        (mem_be_o),
    .mem_addr_o      (mem_addr_o),
    .mem_wd_o        (mem_wd_o),
    .mem_rd_i        (mem_rd_i),
    .mem_ready_i     (mem_ready_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    int          stall;
    int          mis;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] cur_rd = 32'h0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  function automatic logic [3:0] m_be(input logic [2:0] s, input logic [31:0] a);
    case (s)
      3'b000, 3'b100: begin
        case (a[1:0])
          2'd0: return 4'b0001;
          2'd1: return 4'b0010;
          2'd2: return 4'b0100;
          default: return 4'b1000;
        endcase
      end
      3'b001, 3'b101: return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] m_wd(input logic [2:0] s, input logic [31:0] d);
    case (s)
      3'b000, 3'b100: return {d[7:0], d[7:0], d[7:0], d[7:0]};
      3'b001, 3'b101: return {d[15:0], d[15:0]};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] m_ext(input logic [2:0] s, input logic [31:0] a,
                                        input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    case (a[1:0])
      2'd0: b = d[7:0];
      2'd1: b = d[15:8];
      2'd2: b = d[23:16];
      default: b = d[31:24];
    endcase
    h = a[1] ? d[31:16] : d[15:0];
    case (s)
      3'b000:  return b[7] ? {24'hFF_FFFF, b} : {24'h0, b};
      3'b100:  return {24'h0, b};
      3'b001:  return h[15] ? {16'hFFFF, h} : {16'h0, h};
      3'b101:  return {16'h0, h};
      default: return d;
    endcase
  endfunction

  function automatic logic m_misalign(input logic [2:0] s, input logic [31:0] a);
`ifdef LSU_MISALIGN_EN
    if (s == 3'b000 || s == 3'b100) return 1'b0;
    if (s == 3'b001 || s == 3'b101) return a[0];
    return a[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  // One complete access with a wait_n-cycle memory; compares against the queued expectation.
  task automatic access(input string tag, input logic we, input logic [2:0] size,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rdata, input int wait_n);
    exp_t        e;
    exp_t        g;
    logic        mis;
    logic        seen_stall;
    logic        seen_req;
    logic        done;
    int          n_req;
    int          n_stall;
    int          n_mis;
    int          resp_cnt;
    logic        o_we;
    logic [3:0]  o_be;
    logic [31:0] o_addr;
    logic [31:0] o_wd;
    logic [31:0] o_rd;

    mis = m_misalign(size, addr);
    e.req  = !mis;
    e.we   = we;
    e.be   = m_be(size, addr);
    e.addr = addr;
    e.wd   = m_wd(size, wd);
    if (!mis && !we) cur_rd = m_ext(size, addr, rdata);
    e.rd    = cur_rd;
    e.stall = mis ? 1 : 3 + wait_n;
    e.mis   = mis ? 1 : 0;
    sb_q.push_back(e);

    @(posedge clk_i);
    #1;
    core_req_i  = 1'b1;
    core_we_i   = we;
    core_size_i = size;
    core_addr_i = addr;
    core_wd_i   = wd;
    mem_ready_i = 1'b1;   // must be ignored outside RESP
    mem_rd_i    = Garbage;

    seen_stall = 1'b0;
    seen_req   = 1'b0;
    done       = 1'b0;
    n_req      = 0;
    n_stall    = 0;
    n_mis      = 0;
    resp_cnt   = 0;
    o_we = 1'b0; o_be = 4'h0; o_addr = 32'h0; o_wd = 32'h0; o_rd = 32'h0;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      @(negedge clk_i);
      if (core_misalign_o) n_mis++;
      if (core_stall_o) begin
        n_stall++;
        seen_stall = 1'b1;
      end else if (seen_stall) begin
        done = 1'b1;
        o_rd = core_rd_o;
      end
      if (!done) begin
        if (mem_req_o) begin
          n_req++;
          if (n_req == 1) begin
            o_we = mem_we_o; o_be = mem_be_o; o_addr = mem_addr_o; o_wd = mem_wd_o;
          end
          seen_req    = 1'b1;
          resp_cnt    = 0;
          mem_ready_i = 1'b1;
          mem_rd_i    = Garbage;
        end else if (seen_req) begin
          mem_ready_i = (resp_cnt >= wait_n);
          mem_rd_i    = (resp_cnt >= wait_n) ? rdata : Garbage;
          resp_cnt++;
        end
      end
    end
    if (!done) check_eq({tag, ".timeout"}, 32'd1, 32'd0);

    g = sb_q.pop_front();
    check_eq({tag, ".req_pulses"}, n_req, g.req ? 32'd1 : 32'd0);
    check_eq({tag, ".stall_cycles"}, n_stall, g.stall);
    check_eq({tag, ".misalign"}, n_mis, g.mis);
    check_eq({tag, ".core_rd"}, o_rd, g.rd);
    if (g.req) begin
      check_eq({tag, ".we"}, {31'h0, o_we}, {31'h0, g.we});
      check_eq({tag, ".be"}, {28'h0, o_be}, {28'h0, g.be});
      check_eq({tag, ".addr"}, o_addr, g.addr);
      check_eq({tag, ".wd"}, o_wd, g.wd);
    end

    mem_ready_i = 1'b0;
    mem_rd_i    = Garbage;
    @(posedge clk_i);
    #1;
    core_req_i = 1'b0;
  endtask

  initial begin
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [2:0]  sizes [5];
    sizes[0] = 3'b000; sizes[1] = 3'b001; sizes[2] = 3'b010;
    sizes[3] = 3'b100; sizes[4] = 3'b101;

    rst_i       = 1'b1;
    core_req_i  = 1'b1;   // stall must stay low under reset regardless
    core_we_i   = 1'b0;
    core_size_i = 3'b010;
    core_addr_i = 32'h0;
    core_wd_i   = 32'h0;
    mem_rd_i    = Garbage;
    mem_ready_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check_eq("rst.stall", {31'h0, core_stall_o}, 32'h0);
    check_eq("rst.req", {31'h0, mem_req_o}, 32'h0);
    check_eq("rst.we", {31'h0, mem_we_o}, 32'h0);
    check_eq("rst.be", {28'h0, mem_be_o}, 32'h0);
    check_eq("rst.addr", mem_addr_o, 32'h0);
    check_eq("rst.wd", mem_wd_o, 32'h0);
    check_eq("rst.rd", core_rd_o, 32'h0);
    check_eq("rst.mis", {31'h0, core_misalign_o}, 32'h0);
    core_req_i = 1'b0;
    rst_i      = 1'b0;
    @(negedge clk_i);
    check_eq("idle.stall", {31'h0, core_stall_o}, 32'h0);

    access("sw",   1'b1, 3'b010, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0, 0);
    access("sb",   1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 32'h0, 0);
    access("lb",   1'b0, 3'b000, 32'h0000_0102, 32'h0, 32'h1280_3456, 0);
    access("lbu",  1'b0, 3'b100, 32'h0000_0102, 32'h0, 32'h1280_3456, 0);
    access("lh",   1'b0, 3'b001, 32'h0000_0102, 32'h0, 32'h8001_7FFF, 0);
    access("lhu",  1'b0, 3'b101, 32'h0000_0102, 32'h0, 32'h8001_7FFF, 0);
    access("lw_w5", 1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'hCAFE_F00D, 5);
    access("sh",   1'b1, 3'b001, 32'h0000_0106, 32'h1234_BEEF, 32'h0, 1);
    access("lb+",  1'b0, 3'b000, 32'h0000_0101, 32'h0, 32'h0000_7F00, 0);
    access("sz011", 1'b0, 3'b011, 32'h0000_0200, 32'h0, 32'h8765_4321, 2);
    access("sz110", 1'b1, 3'b110, 32'h0000_0204, 32'h0BAD_CAFE, 32'h0, 0);
    // Misaligned accesses: trapped with the macro, otherwise lane-selected on low bits.
    access("lw_mis", 1'b0, 3'b010, 32'h0000_0102, 32'h0, 32'hA1B2_C3D4, 0);
    access("lh_mis", 1'b0, 3'b001, 32'h0000_0103, 32'h0, 32'hF00F_1234, 0);

    for (int i = 0; i < 8; i++) begin
      we   = 1'($urandom_range(0, 1));
      size = sizes[$urandom_range(0, 4)];
      addr = $urandom & 32'h0000_FFFF;
      if (size[1:0] == 2'b01) addr[0] = 1'b0;
      if (size[1:0] == 2'b10) addr[1:0] = 2'b00;
      access("rnd", we, size, addr, $urandom, $urandom, $urandom_range(0, 3));
    end

    // Reset in RESP: access abandoned, outputs cleared, FSM back in IDLE.
    @(posedge clk_i);
    #1;
    core_req_i  = 1'b1;
    core_we_i   = 1'b0;
    core_size_i = 3'b010;
    core_addr_i = 32'h0000_0300;
    mem_ready_i = 1'b0;
    begin
      int k;
      k = 0;
      while (!mem_req_o && k < 10) begin
        @(negedge clk_i);
        k++;
      end
      check_eq("rstmid.reached_req", {31'h0, mem_req_o}, 32'h1);
    end
    @(negedge clk_i);   // now in RESP
    rst_i      = 1'b1;
    core_req_i = 1'b0;
    @(negedge clk_i);
    check_eq("rstmid.stall", {31'h0, core_stall_o}, 32'h0);
    check_eq("rstmid.req", {31'h0, mem_req_o}, 32'h0);
    check_eq("rstmid.rd", core_rd_o, 32'h0);
    rst_i  = 1'b0;
    cur_rd = 32'h0;
    @(negedge clk_i);
    check_eq("rstmid.idle_stall", {31'h0, core_stall_o}, 32'h0);
    check_eq("rstmid.idle_req", {31'h0, mem_req_o}, 32'h0);
    access("post_rst", 1'b0, 3'b101, 32'h0000_0302, 32'h0, 32'hBEEF_0001, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
